// File: rtl/cnn_pkg.sv
// Shared CNN layer definitions: word width,
// layer FSM state encoding and signed compare.
package cnn_pkg;

    localparam int DATA_W = 16;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        LAST = 3'd2,
        WR   = 3'd3,
        DONE = 3'd4
    } state_t;

    // Signed-max select: 1 when nxt must replace cur.
    // Strict compare, so a tie keeps the earlier value.
    function automatic logic smax_sel(
        input logic signed [63:0] cur,
        input logic signed [63:0] nxt
    );
        return nxt > cur;
    endfunction

endpackage

// File: rtl/pool_engine_if.sv
// Layer handshake plus input/output buffer ports
// of one pooling engine.
interface pool_engine_if #(
    parameter int DATA_W = cnn_pkg::DATA_W,
    parameter int ADDR_W = 10
);
    logic              start;
    logic              busy;
    logic              done;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    modport master (
        output start, rd_data,
        input  busy, done, rd_en, rd_addr,
        input  wr_en, wr_addr, wr_data
    );

    modport slave (
        input  start, rd_data,
        output busy, done, rd_en, rd_addr,
        output wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/pool_addr_gen.sv
// Window/quad counters and registered read/write
// addresses for 2x2 stride-2 pooling.
module pool_addr_gen #(
    parameter int IN_H     = 24,
    parameter int IN_W     = 24,
    parameter int ADDR_W   = 10,
    parameter int IN_BASE  = 0,
    parameter int OUT_BASE = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_go_i,
    input  logic              wr_go_i,
    output logic [ADDR_W-1:0] rd_addr_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [1:0]        rd_q_o,
    output logic              last_win_o
);
    localparam int OH = IN_H / 2;
    localparam int OW = IN_W / 2;

    logic [ADDR_W-1:0] r_q;
    logic [ADDR_W-1:0] c_q;
    logic [1:0]        q_q;
    logic [1:0]        rd_q_q;
    logic [ADDR_W-1:0] rd_addr_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic              last_q;

    logic [ADDR_W-1:0] off_d;
    logic [ADDR_W-1:0] rd_addr_d;
    logic [ADDR_W-1:0] wr_addr_d;
    logic              win_last_d;

    // Quad offset inside the 2x2 window.
    always_comb begin
        off_d = '0;
        unique case (q_q)
            2'd0:    off_d = '0;
            2'd1:    off_d = ADDR_W'(1);
            2'd2:    off_d = ADDR_W'(IN_W);
            default: off_d = ADDR_W'(IN_W + 1);
        endcase
    end

    assign rd_addr_d = ADDR_W'(IN_BASE)
                     + r_q * ADDR_W'(2 * IN_W)
                     + (c_q << 1)
                     + off_d;

    assign wr_addr_d = ADDR_W'(OUT_BASE)
                     + r_q * ADDR_W'(OW)
                     + c_q;

    assign win_last_d = (r_q == ADDR_W'(OH - 1))
                     && (c_q == ADDR_W'(OW - 1));

    // Issue addresses and step quad/window counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q       <= '0;
            c_q       <= '0;
            q_q       <= '0;
            rd_q_q    <= '0;
            rd_addr_q <= '0;
            wr_addr_q <= '0;
            last_q    <= 1'b0;
        end else begin
            rd_addr_q <= rd_go_i ? rd_addr_d : '0;
            wr_addr_q <= wr_go_i ? wr_addr_d : '0;
            if (rd_go_i) begin
                rd_q_q <= q_q;
                q_q    <= q_q + 2'd1;
            end
            if (wr_go_i) begin
                last_q <= win_last_d;
                if (c_q == ADDR_W'(OW - 1)) begin
                    c_q <= '0;
                    if (r_q == ADDR_W'(OH - 1))
                        r_q <= '0;
                    else
                        r_q <= r_q + 1'b1;
                end else begin
                    c_q <= c_q + 1'b1;
                end
            end
        end
    end

    assign rd_addr_o  = rd_addr_q;
    assign wr_addr_o  = wr_addr_q;
    assign rd_q_o     = rd_q_q;
    assign last_win_o = last_q;
endmodule

// File: rtl/pool_engine.sv
// 2x2 stride-2 max-pooling layer engine:
// start strobe in, one done pulse out.
module pool_engine #(
    parameter int DATA_W   = cnn_pkg::DATA_W,
    parameter int IN_H     = 24,
    parameter int IN_W     = 24,
    parameter int ADDR_W   = 10,
    parameter int IN_BASE  = 0,
    parameter int OUT_BASE = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    pool_engine_if.slave  bus
);
    import cnn_pkg::*;

    state_t                   state_q;
    logic                     busy_q;
    logic                     done_q;
    logic                     rd_en_q;
    logic                     wr_en_q;
    logic signed [DATA_W-1:0] max_q;
    logic signed [DATA_W-1:0] wr_data_q;

    logic signed [DATA_W-1:0] rdv;
    logic signed [DATA_W-1:0] fold_d;
    logic                     rd_go;
    logic                     wr_go;
    logic [1:0]               rd_q;
    logic                     last_win;
    logic [ADDR_W-1:0]        rd_addr;
    logic [ADDR_W-1:0]        wr_addr;

    assign rdv = bus.rd_data;

    assign fold_d = smax_sel(64'(max_q), 64'(rdv))
                  ? rdv : max_q;

    // Cycles whose successor issues a read or the write.
    always_comb begin
        rd_go = 1'b0;
        wr_go = 1'b0;
        unique case (state_q)
            IDLE:    rd_go = bus.start;
            RD:      rd_go = (rd_q != 2'd3);
            LAST:    wr_go = 1'b1;
            WR:      rd_go = !last_win;
            default: rd_go = 1'b0;
        endcase
    end

    pool_addr_gen #(
        .IN_H     (IN_H),
        .IN_W     (IN_W),
        .ADDR_W   (ADDR_W),
        .IN_BASE  (IN_BASE),
        .OUT_BASE (OUT_BASE)
    ) u_addr (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_go_i    (rd_go),
        .wr_go_i    (wr_go),
        .rd_addr_o  (rd_addr),
        .wr_addr_o  (wr_addr),
        .rd_q_o     (rd_q),
        .last_win_o (last_win)
    );

    // Layer FSM with max fold and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rd_en_q   <= 1'b0;
            wr_en_q   <= 1'b0;
            max_q     <= '0;
            wr_data_q <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        state_q <= RD;
                        busy_q  <= 1'b1;
                        rd_en_q <= 1'b1;
                    end
                end
                RD: begin
                    if (rd_q == 2'd1)
                        max_q <= rdv;
                    else if (rd_q != 2'd0)
                        max_q <= fold_d;
                    if (rd_q == 2'd3) begin
                        state_q <= LAST;
                        rd_en_q <= 1'b0;
                    end
                end
                LAST: begin
                    max_q     <= fold_d;
                    wr_data_q <= fold_d;
                    wr_en_q   <= 1'b1;
                    state_q   <= WR;
                end
                WR: begin
                    wr_en_q <= 1'b0;
                    if (last_win) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= RD;
                        rd_en_q <= 1'b1;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.rd_en   = rd_en_q;
    assign bus.rd_addr = rd_addr;
    assign bus.wr_en   = wr_en_q;
    assign bus.wr_addr = wr_addr;
    assign bus.wr_data = wr_data_q;
endmodule

// File: tb/tb_pool_engine.sv
// Bench for pool_engine: table vectors, random maps
// against a plain max-of-four model, corner sequences.
module tb_pool_engine;

    logic clk;
    logic rst_n;
    logic [2:0] start_v;
    int cyc = 0;
    int ts = 0;
    int nvec = 0;
    int nerr = 0;

    logic signed [15:0] mem [3][1024];
    int img [64];
    int wcnt [3];
    int waddr [3][512];
    int wdata [3][512];
    int bad_b = 0;
    int saw_zero = 0;

    pool_engine_if #(.DATA_W(16), .ADDR_W(10)) ifa ();
    pool_engine_if #(.DATA_W(16), .ADDR_W(10)) ifb ();
    pool_engine_if #(.DATA_W(16), .ADDR_W(10)) ifc ();

    pool_engine #(
        .DATA_W(16), .IN_H(4), .IN_W(4), .ADDR_W(10),
        .IN_BASE(0), .OUT_BASE(32)
    ) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));

    pool_engine #(
        .DATA_W(16), .IN_H(5), .IN_W(5), .ADDR_W(10),
        .IN_BASE(0), .OUT_BASE(100)
    ) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

    pool_engine #(
        .DATA_W(16), .IN_H(4), .IN_W(4), .ADDR_W(10),
        .IN_BASE(1022), .OUT_BASE(0)
    ) dut_c (.clk(clk), .rst_n(rst_n), .bus(ifc));

    assign ifa.start = start_v[0];
    assign ifb.start = start_v[1];
    assign ifc.start = start_v[2];

    logic [2:0] busy_v;
    logic [2:0] done_v;
    logic [2:0] wen_v;
    logic [9:0] wad_v [3];
    logic [15:0] wdt_v [3];

    assign busy_v = {ifc.busy, ifb.busy, ifa.busy};
    assign done_v = {ifc.done, ifb.done, ifa.done};
    assign wen_v  = {ifc.wr_en, ifb.wr_en, ifa.wr_en};
    assign wad_v[0] = ifa.wr_addr;
    assign wad_v[1] = ifb.wr_addr;
    assign wad_v[2] = ifc.wr_addr;
    assign wdt_v[0] = ifa.wr_data;
    assign wdt_v[1] = ifb.wr_data;
    assign wdt_v[2] = ifc.wr_data;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Input buffers: data one cycle after rd_en.
    always @(posedge clk) begin
        if (ifa.rd_en) ifa.rd_data <= mem[0][ifa.rd_addr];
        if (ifb.rd_en) ifb.rd_data <= mem[1][ifb.rd_addr];
        if (ifc.rd_en) ifc.rd_data <= mem[2][ifc.rd_addr];
    end

    // Output buffer logs and read-address monitors.
    always @(negedge clk) begin
        for (int s = 0; s < 3; s++) begin
            if (wen_v[s]) begin
                waddr[s][wcnt[s] % 512] = int'(wad_v[s]);
                wdata[s][wcnt[s] % 512] =
                    int'($signed(wdt_v[s]));
                wcnt[s] = wcnt[s] + 1;
            end
        end
        if (ifb.rd_en) begin
            if ((int'(ifb.rd_addr) / 5) == 4 ||
                (int'(ifb.rd_addr) % 5) == 4)
                bad_b = bad_b + 1;
        end
        if (ifc.rd_en && ifc.rd_addr == 10'd0)
            saw_zero = 1;
    end

    task automatic chk(input string nm,
                       input longint got,
                       input longint exp);
        nvec = nvec + 1;
        if (got !== exp) begin
            nerr = nerr + 1;
            $display("FAIL %s: got %0d, expected %0d",
                     nm, got, exp);
        end
    endtask

    task automatic load(input int sel, input int h,
                        input int w, input int base);
        for (int k = 0; k < h * w; k++)
            mem[sel][(base + k) % 1024] = 16'(img[k]);
    endtask

    task automatic pulse_start(input int sel);
        @(negedge clk);
        start_v[sel] = 1'b1;
        ts = cyc + 1;
        @(negedge clk);
        start_v[sel] = 1'b0;
    endtask

    task automatic wait_done(input int sel,
                             output int drel,
                             output int bcnt,
                             output int bfirst);
        int rel;
        drel = -1;
        bcnt = 0;
        bfirst = -1;
        for (int k = 0; k < 2000; k++) begin
            rel = cyc + 1 - ts;
            if (busy_v[sel]) begin
                bcnt = bcnt + 1;
                if (bfirst < 0) bfirst = rel;
            end
            if (done_v[sel]) begin
                drel = rel;
                break;
            end
            @(negedge clk);
        end
    endtask

    // Reference: each output is the plain max of its
    // four input pixels, written row-major.
    task automatic verify(input int sel, input int h,
                          input int w, input int obase,
                          input int w0, input string tag);
        int oh, ow, mx, p, idx;
        oh = h / 2;
        ow = w / 2;
        chk({tag, " wr count"}, wcnt[sel] - w0, oh * ow);
        for (int r = 0; r < oh; r++) begin
            for (int c = 0; c < ow; c++) begin
                mx = -100000;
                for (int dy = 0; dy < 2; dy++)
                    for (int dx = 0; dx < 2; dx++) begin
                        p = img[(2*r + dy) * w + 2*c + dx];
                        if (p > mx) mx = p;
                    end
                idx = (w0 + r * ow + c) % 512;
                chk($sformatf("%s addr r%0d c%0d", tag, r, c),
                    waddr[sel][idx],
                    (obase + r * ow + c) % 1024);
                chk($sformatf("%s data r%0d c%0d", tag, r, c),
                    wdata[sel][idx], mx);
            end
        end
    endtask

    task automatic run_full(input int sel, input int h,
                            input int w, input int base,
                            input int obase,
                            input string tag);
        int w0, drel, bc, bf, n;
        load(sel, h, w, base);
        w0 = wcnt[sel];
        pulse_start(sel);
        wait_done(sel, drel, bc, bf);
        n = (h / 2) * (w / 2);
        chk({tag, " done cycle"}, drel, 6 * n + 1);
        chk({tag, " busy cycles"}, bc, 6 * n);
        chk({tag, " busy first"}, bf, 1);
        @(negedge clk);
        @(negedge clk);
        verify(sel, h, w, obase, w0, tag);
    endtask

    task automatic rand_img(input int n);
        logic [15:0] t16;
        for (int k = 0; k < n; k++) begin
            t16 = 16'($urandom);
            img[k] = int'($signed(t16));
        end
    endtask

    typedef struct packed {
        logic [15:0][15:0] img;
        logic [3:0][15:0]  ex;
    } vec_t;

    vec_t tv [3];

    initial begin
        int negs [16] = '{
            -5, -3, -7, -8,
            -4, -1, -9, -10,
            -20, -2, -32768, -100,
            -30, -40, -1, -32768
        };
        int ties [16] = '{
            3, 9, 1, 4,
            9, 2, 4, 4,
            -6, -6, 0, 0,
            -6, -6, 0, 0
        };
        int w0, drel, bc, bf, nb, nd, base;

        for (int k = 0; k < 16; k++) begin
            tv[0].img[k] = 16'(k);
            tv[1].img[k] = 16'(negs[k]);
            tv[2].img[k] = 16'(ties[k]);
        end
        tv[0].ex[0] = 16'd5;
        tv[0].ex[1] = 16'd7;
        tv[0].ex[2] = 16'd13;
        tv[0].ex[3] = 16'd15;
        tv[1].ex[0] = 16'(-1);
        tv[1].ex[1] = 16'(-7);
        tv[1].ex[2] = 16'(-2);
        tv[1].ex[3] = 16'(-1);
        tv[2].ex[0] = 16'd9;
        tv[2].ex[1] = 16'd4;
        tv[2].ex[2] = 16'(-6);
        tv[2].ex[3] = 16'd0;

        for (int s = 0; s < 3; s++) begin
            wcnt[s] = 0;
            for (int a = 0; a < 1024; a++)
                mem[s][a] = 16'($urandom);
        end

        rst_n = 1'b0;
        start_v = 3'b000;
        repeat (3) @(negedge clk);
        chk("rst busy", ifa.busy, 0);
        chk("rst done", ifa.done, 0);
        chk("rst rd_en", ifa.rd_en, 0);
        chk("rst wr_en", ifa.wr_en, 0);
        chk("rst rd_addr", ifa.rd_addr, 0);
        chk("rst wr_addr", ifa.wr_addr, 0);
        chk("rst wr_data", ifa.wr_data, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle busy", ifa.busy, 0);

        // Table vectors on the 4x4 engine.
        for (int i = 0; i < 3; i++) begin
            for (int k = 0; k < 16; k++)
                img[k] = int'($signed(tv[i].img[k]));
            run_full(0, 4, 4, 0, 32,
                     $sformatf("tv%0d", i));
            for (int j = 0; j < 4; j++)
                chk($sformatf("tv%0d exp%0d", i, j),
                    wdata[0][(wcnt[0] - 4 + j) % 512],
                    int'($signed(tv[i].ex[j])));
        end

        // 5x5 map: odd row/column ignored.
        for (int k = 0; k < 25; k++) img[k] = k;
        run_full(1, 5, 5, 0, 100, "odd5");
        w0 = wcnt[1] - 4;
        chk("odd5 v0", wdata[1][w0 % 512], 6);
        chk("odd5 v1", wdata[1][(w0 + 1) % 512], 8);
        chk("odd5 v2", wdata[1][(w0 + 2) % 512], 16);
        chk("odd5 v3", wdata[1][(w0 + 3) % 512], 18);
        chk("odd5 edge reads", bad_b, 0);

        // Base near the top of the address space.
        rand_img(16);
        run_full(2, 4, 4, 1022, 0, "wrap");
        chk("wrap saw addr 0", saw_zero, 1);

        // Start strobes inside RD, WR and DONE.
        rand_img(16);
        load(0, 4, 4, 0);
        w0 = wcnt[0];
        pulse_start(0);
        drel = -1;
        for (int k = 0; k < 200; k++) begin
            start_v[0] = ((cyc + 1 - ts) == 2 ||
                          (cyc + 1 - ts) == 6 ||
                          (cyc + 1 - ts) == 12);
            if (done_v[0]) begin
                drel = cyc + 1 - ts;
                break;
            end
            @(negedge clk);
        end
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        chk("ign done cycle", drel, 25);
        nb = 0;
        nd = 0;
        for (int k = 0; k < 40; k++) begin
            if (ifa.busy) nb = nb + 1;
            if (ifa.done) nd = nd + 1;
            @(negedge clk);
        end
        chk("ign no restart busy", nb, 0);
        chk("ign no extra done", nd, 0);
        verify(0, 4, 4, 32, w0, "ign");

        // Reset during the second window's reads.
        rand_img(16);
        load(0, 4, 4, 0);
        w0 = wcnt[0];
        pulse_start(0);
        for (int k = 0; k < 50; k++) begin
            if ((cyc + 1 - ts) >= 8) break;
            @(negedge clk);
        end
        chk("mid rd_en before rst", ifa.rd_en, 1);
        rst_n = 1'b0;
        #1;
        chk("mid rst busy", ifa.busy, 0);
        chk("mid rst rd_en", ifa.rd_en, 0);
        chk("mid rst rd_addr", ifa.rd_addr, 0);
        chk("mid rst wr_en", ifa.wr_en, 0);
        chk("mid rst wr_data", ifa.wr_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        nd = 0;
        for (int k = 0; k < 40; k++) begin
            if (ifa.done) nd = nd + 1;
            @(negedge clk);
        end
        chk("mid rst no done", nd, 0);
        chk("mid rst writes", wcnt[0] - w0, 1);
        run_full(0, 4, 4, 0, 32, "after rst");

        // Random maps on every engine.
        for (int it = 0; it < 6; it++) begin
            rand_img(16);
            run_full(0, 4, 4, 0, 32,
                     $sformatf("rndA%0d", it));
        end
        for (int it = 0; it < 2; it++) begin
            rand_img(25);
            run_full(1, 5, 5, 0, 100,
                     $sformatf("rndB%0d", it));
            rand_img(16);
            base = 1022;
            run_full(2, 4, 4, base, 0,
                     $sformatf("rndC%0d", it));
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 nvec, nerr);
        $finish;
    end

endmodule
